// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module   : if_fetch_unit_if
// Purpose  : Instruction bus bundle (req/gnt/rvalid word fetch channel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
    logic        req_o;
    logic [31:0] addr_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;

    modport master (
        output req_o,
        output addr_o,
        input  gnt_i,
        input  rvalid_i,
        input  rdata_i
    );

    modport slave (
        input  req_o,
        input  addr_o,
        output gnt_i,
        output rvalid_i,
        output rdata_i
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction fetch front end: PC, single-outstanding bus fetch,
//            fetch FIFO and jump redirect. Optional misaligned-redirect check
//            enabled by defining FETCH_MISALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter logic [31:0] NOP_INS    = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_en_i,
    input  logic [31:0]            jump_addr_i,
    input  logic                   hold_flag_i,
    if_fetch_unit_if.master        ibus,
    output logic [31:0]            ins_o,
    output logic [31:0]            ins_addr_o,
    output logic                   ins_valid_o,
    input  logic                   ins_ready_i,
    output logic                   misalign_o
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        req_addr_q;

    logic [31:0]        data_q [BUF_DEPTH];
    logic [31:0]        addr_q [BUF_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_credit;
    logic               w_inflight_d;
    logic               w_jump_bad;
    logic               w_misalign;
    logic [31:0]        w_jump_target;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    // Sticky until the next jump; an aligned jump clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (jump_en_i) begin
            misalign_q <= (jump_addr_i[1:0] != 2'b00);
        end
    end

    assign w_jump_bad    = (jump_addr_i[1:0] != 2'b00);
    assign w_jump_target = jump_addr_i;
    assign w_misalign    = misalign_q;
    assign misalign_o    = misalign_q;
`else
    assign w_jump_bad    = 1'b0;
    assign w_jump_target = jump_addr_i & 32'hFFFF_FFFC;
    assign w_misalign    = 1'b0;
    assign misalign_o    = 1'b0;
`endif

    assign w_empty     = (count_q == '0);
    assign ins_valid_o = !w_empty && !hold_flag_i;
    assign ins_o       = w_empty ? NOP_INS : data_q[rd_ptr_q];
    assign ins_addr_o  = w_empty ? 32'h0   : addr_q[rd_ptr_q];

    assign w_pop    = ins_valid_o && ins_ready_i && !jump_en_i;
    assign w_push   = (state_q == S_WAIT) && ibus.rvalid_i && !jump_en_i;
    assign w_credit = (count_q < C_DEPTH);

    // A response is still owed by the bus after this clock edge.
    assign w_inflight_d = ((state_q == S_REQ) && ibus.gnt_i) ||
                          (((state_q == S_WAIT) || (state_q == S_DROP)) && !ibus.rvalid_i);

    assign ibus.req_o  = (state_q == S_REQ);
    assign ibus.addr_o = pc_q;

    always_comb begin
        count_d = count_q;
        if (jump_en_i) begin
            count_d = '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_ADDR;
            req_addr_q <= 32'h0;
        end else if (jump_en_i) begin
            if (!w_jump_bad) begin
                pc_q <= w_jump_target;
            end
            // A response landing in this very cycle is simply discarded, so
            // DROP is only needed when the bus still owes one.
            if (w_inflight_d) begin
                state_q <= S_DROP;
            end else if (w_jump_bad) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= S_REQ;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (w_credit && !w_misalign) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ibus.gnt_i) begin
                        req_addr_q <= pc_q;
                        pc_q       <= pc_q + 32'd4;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ibus.rvalid_i) begin
                        state_q <= (count_d < C_DEPTH) ? S_REQ : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (ibus.rvalid_i) begin
                        state_q <= w_misalign ? S_IDLE : S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (jump_en_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (w_push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (w_push) begin
            data_q[wr_ptr_q] <= ibus.rdata_i;
            addr_q[wr_ptr_q] <= req_addr_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Directed self-checking bench for if_fetch_unit with a bus
//            responder returning rdata = {16'hC0DE, addr[15:0]}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        hold_flag_i = 1'b0;
    logic        ins_ready_i = 1'b1;
    logic [31:0] ins_o;
    logic [31:0] ins_addr_o;
    logic        ins_valid_o;
    logic        misalign_o;

    if_fetch_unit_if ibus ();

    if_fetch_unit #(
        .RESET_ADDR (32'h0000_0000),
        .BUF_DEPTH  (2),
        .NOP_INS    (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .hold_flag_i (hold_flag_i),
        .ibus        (ibus),
        .ins_o       (ins_o),
        .ins_addr_o  (ins_addr_o),
        .ins_valid_o (ins_valid_o),
        .ins_ready_i (ins_ready_i),
        .misalign_o  (misalign_o)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          gnt_delay = 0;
    int          rv_delay = 1;
    int          wcnt = 0;
    int          pend = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] gnt_log [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    // Bus responder and consumer monitor, both decided on the falling edge.
    initial begin
        ibus.gnt_i    = 1'b0;
        ibus.rvalid_i = 1'b0;
        ibus.rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && ins_valid_o && ins_ready_i && !jump_en_i) begin
                log_addr.push_back(ins_addr_o);
                log_data.push_back(ins_o);
            end
            ibus.gnt_i    = 1'b0;
            ibus.rvalid_i = 1'b0;
            if (rst) begin
                pend = 0;
                wcnt = 0;
            end else if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    ibus.rvalid_i = 1'b1;
                    ibus.rdata_i  = {16'hC0DE, pend_addr[15:0]};
                end
            end else if (ibus.req_o) begin
                if (wcnt >= gnt_delay) begin
                    ibus.gnt_i = 1'b1;
                    pend_addr  = ibus.addr_o;
                    gnt_log.push_back(ibus.addr_o);
                    pend = rv_delay;
                    wcnt = 0;
                end else begin
                    wcnt = wcnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int want, input int budget);
        int k = 0;
        while (log_addr.size() < want && k < budget) begin
            tick();
            k++;
        end
        if (log_addr.size() < want) tmo("wait_log");
    endtask

    task automatic wait_gnt(input int budget);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!ibus.gnt_i && k < budget);
        if (!ibus.gnt_i) tmo("wait_gnt");
    endtask

    function automatic logic [31:0] la(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] ld(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] gl(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : 32'hDEAD_DEAD;
    endfunction

    initial begin
        int base;
        int gbase;

        // Reset values
        tick(3);
        chk("rst_req",   32'(ibus.req_o), 32'd0);
        chk("rst_valid", 32'(ins_valid_o), 32'd0);
        chk("rst_ins",   ins_o, 32'h0000_0013);
        chk("rst_iaddr", ins_addr_o, 32'h0);
        chk("rst_mis",   32'(misalign_o), 32'd0);
        rst = 1'b0;

        // Sequential fetch with a streaming consumer
        wait_log(3, 40);
        ins_ready_i = 1'b0;
        chk("seq_a0", la(0), 32'h0000_0000);
        chk("seq_d0", ld(0), 32'hC0DE_0000);
        chk("seq_a1", la(1), 32'h0000_0004);
        chk("seq_d1", ld(1), 32'hC0DE_0004);
        chk("seq_a2", la(2), 32'h0000_0008);
        chk("seq_d2", ld(2), 32'hC0DE_0008);
        chk("seq_g0", gl(0), 32'h0000_0000);
        chk("seq_g1", gl(1), 32'h0000_0004);
        chk("seq_g2", gl(2), 32'h0000_0008);

        // Consumer stalled: FIFO fills to two entries and requests stop
        tick(6);
        chk("full_req",  32'(ibus.req_o), 32'd0);
        chk("full_vld",  32'(ins_valid_o), 32'd1);
        chk("full_head", ins_addr_o, 32'h0000_000C);
        chk("full_gnts", 32'(gnt_log.size()), 32'd5);
        chk("full_nopop", 32'(log_addr.size()), 32'd3);

        // Hold masks valid without losing entries
        hold_flag_i = 1'b1;
        #1;
        chk("hold_vld", 32'(ins_valid_o), 32'd0);
        ins_ready_i = 1'b1;
        tick(3);
        chk("hold_vld2",  32'(ins_valid_o), 32'd0);
        chk("hold_nopop", 32'(log_addr.size()), 32'd3);
        chk("hold_head",  ins_addr_o, 32'h0000_000C);
        hold_flag_i = 1'b0;
        #1;
        chk("rel_vld",  32'(ins_valid_o), 32'd1);
        chk("rel_head", ins_addr_o, 32'h0000_000C);
        wait_log(5, 20);
        chk("rel_a3", la(3), 32'h0000_000C);
        chk("rel_d3", ld(3), 32'hC0DE_000C);
        chk("rel_a4", la(4), 32'h0000_0010);

        // Jump while a response is outstanding: stale data must be dropped
        rv_delay = 4;
        wait_gnt(20);
        base  = log_addr.size();
        gbase = gnt_log.size();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0100;
        tick();
        jump_en_i = 1'b0;
        chk("drop_vld", 32'(ins_valid_o), 32'd0);
        chk("drop_req", 32'(ibus.req_o), 32'd0);
        wait_log(base + 1, 40);
        chk("jmp_addr", la(base), 32'h0000_0100);
        chk("jmp_data", ld(base), 32'hC0DE_0100);
        chk("jmp_gnt",  gl(gbase), 32'h0000_0100);
        rv_delay = 1;

        // Delayed grant: address stable, then retargeted by a jump
        ins_ready_i = 1'b0;
        tick(15);
        chk("idle_req", 32'(ibus.req_o), 32'd0);
        base  = log_addr.size();
        gbase = gnt_log.size();
        gnt_delay   = 3;
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0200;
        tick();
        jump_en_i = 1'b0;
        chk("jr_req",  32'(ibus.req_o), 32'd1);
        chk("jr_addr", ibus.addr_o, 32'h0000_0200);
        chk("jr_vld",  32'(ins_valid_o), 32'd0);
        tick();
        chk("stall_req",  32'(ibus.req_o), 32'd1);
        chk("stall_addr", ibus.addr_o, 32'h0000_0200);
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0300;
        tick();
        jump_en_i = 1'b0;
        chk("sw_req",  32'(ibus.req_o), 32'd1);
        chk("sw_addr", ibus.addr_o, 32'h0000_0300);
        tick(3);
        chk("dly_gnt",  gl(gbase), 32'h0000_0300);
        chk("dly_ngnt", 32'(gnt_log.size() - gbase), 32'd1);
        gnt_delay   = 0;
        ins_ready_i = 1'b1;
        wait_log(base + 1, 20);
        chk("sw_ins_a", la(base), 32'h0000_0300);
        chk("sw_ins_d", ld(base), 32'hC0DE_0300);

        // PC wraps modulo 2^32
        ins_ready_i = 1'b0;
        tick(15);
        gbase = gnt_log.size();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'hFFFF_FFFC;
        tick();
        jump_en_i = 1'b0;
        tick(10);
        chk("wrap_g0",  gl(gbase), 32'hFFFF_FFFC);
        chk("wrap_g1",  gl(gbase + 1), 32'h0000_0000);
        chk("wrap_hd",  ins_addr_o, 32'hFFFF_FFFC);
        chk("wrap_ins", ins_o, 32'hC0DE_FFFC);
        chk("wrap_req", 32'(ibus.req_o), 32'd0);

`ifdef FETCH_MISALIGN_CHK_EN
        gbase = gnt_log.size();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0102;
        tick();
        jump_en_i = 1'b0;
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_vld",  32'(ins_valid_o), 32'd0);
        chk("mis_req",  32'(ibus.req_o), 32'd0);
        tick(5);
        chk("mis_req2",  32'(ibus.req_o), 32'd0);
        chk("mis_flag2", 32'(misalign_o), 32'd1);
        chk("mis_nogn",  32'(gnt_log.size() - gbase), 32'd0);
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0200;
        tick();
        jump_en_i = 1'b0;
        chk("mis_clr",  32'(misalign_o), 32'd0);
        chk("mis_rreq", 32'(ibus.req_o), 32'd1);
        chk("mis_addr", ibus.addr_o, 32'h0000_0200);
`else
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0102;
        tick();
        jump_en_i = 1'b0;
        chk("unal_flag", 32'(misalign_o), 32'd0);
        chk("unal_req",  32'(ibus.req_o), 32'd1);
        chk("unal_addr", ibus.addr_o, 32'h0000_0100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
